// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: state encoding, datapath select codes and RV32I opcodes
// shared by the multi-cycle control FSM and its decoders.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_AUIPC, C_JAL, C_JALR, C_ILLEGAL
   } iclass_t;

   localparam logic [2:0] IMM_I    = 3'd0;
   localparam logic [2:0] IMM_S    = 3'd1;
   localparam logic [2:0] IMM_B    = 3'd2;
   localparam logic [2:0] IMM_U    = 3'd3;
   localparam logic [2:0] IMM_J    = 3'd4;
   localparam logic [2:0] IMM_NONE = 3'd7;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   localparam logic [1:0] PC_SEQ = 2'd0;
   localparam logic [1:0] PC_IMM = 2'd1;
   localparam logic [1:0] PC_ALU = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   localparam logic [1:0] ALU_A_RS1  = 2'd0;
   localparam logic [1:0] ALU_A_PC   = 2'd1;
   localparam logic [1:0] ALU_A_ZERO = 2'd2;
   localparam logic       ALU_B_RS2  = 1'b0;
   localparam logic       ALU_B_IMM  = 1'b1;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   function automatic iclass_t classify(input logic [6:0] opc);
      iclass_t c;
      case (opc)
         OPC_OP:     c = C_R;
         OPC_OPIMM:  c = C_IALU;
         OPC_LOAD:   c = C_LOAD;
         OPC_STORE:  c = C_STORE;
         OPC_BRANCH: c = C_BRANCH;
         OPC_LUI:    c = C_LUI;
         OPC_AUIPC:  c = C_AUIPC;
         OPC_JAL:    c = C_JAL;
         OPC_JALR:   c = C_JALR;
         default:    c = C_ILLEGAL;
      endcase
      return c;
   endfunction

   function automatic logic [2:0] imm_fmt(input iclass_t c);
      logic [2:0] f;
      case (c)
         C_IALU, C_LOAD, C_JALR: f = IMM_I;
         C_STORE:                f = IMM_S;
         C_BRANCH:               f = IMM_B;
         C_LUI, C_AUIPC:         f = IMM_U;
         C_JAL:                  f = IMM_J;
         default:                f = IMM_NONE;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control bundle between the FSM (master) and the datapath
// plus memory port (slave).
interface multicycle_ctrl_if;
   logic [31:0] inst;
   logic        br_taken;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic        mem_addr_sel;
   logic        ir_we;
   logic        pc_we;
   logic [1:0]  pc_sel;
   logic [2:0]  imm_sel;
   logic [1:0]  alu_a_sel;
   logic        alu_b_sel;
   logic [3:0]  alu_op;
   logic        reg_we;
   logic [1:0]  wb_sel;
   logic [2:0]  state_o;
   logic        fault;

   modport master (
      input  inst, br_taken, mem_ready,
      output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, imm_sel,
             alu_a_sel, alu_b_sel, alu_op, reg_we, wb_sel, state_o, fault
   );

   modport slave (
      output inst, br_taken, mem_ready,
      input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, imm_sel,
             alu_a_sel, alu_b_sel, alu_op, reg_we, wb_sel, state_o, fault
   );
endinterface

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// alu_op_decode: opcode/funct3/funct7[5] to ALU operation. funct7[5] only
// matters for SUB (R-type) and SRA/SRAI.
module alu_op_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_b5,
   output logic [3:0] alu_op
);

   always_comb begin
      alu_op = ALU_ADD;
      if (opcode == OPC_OP || opcode == OPC_OPIMM) begin
         case (funct3)
            3'd0:    alu_op = (opcode == OPC_OP && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'd1:    alu_op = ALU_SLL;
            3'd2:    alu_op = ALU_SLT;
            3'd3:    alu_op = ALU_SLTU;
            3'd4:    alu_op = ALU_XOR;
            3'd5:    alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'd6:    alu_op = ALU_OR;
            default: alu_op = ALU_AND;
         endcase
      end else if (opcode == OPC_BRANCH) begin
         alu_op = ALU_SUB;
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer over one shared memory port.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to fault on unrecognised opcodes.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic              clk,
   input  logic              rst,
   multicycle_ctrl_if.master bus
);

   localparam int            CW        = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

   state_t        state, state_nx;
   logic [CW-1:0] wait_cnt;
   logic          wait_hit;
   iclass_t       cls;
   logic [3:0]    dec_alu_op;
   logic [1:0]    a_sel;
   logic          b_sel;
   logic          mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we;
   logic [1:0]    pc_sel, wb_sel, alu_a_sel;
   logic          alu_b_sel;
   logic [3:0]    alu_op;
   logic [2:0]    imm_sel;
   logic          unused_inst;

   assign cls         = classify(bus.inst[6:0]);
   assign unused_inst = ^{bus.inst[31], bus.inst[29:15], bus.inst[11:7]};

   alu_op_decode u_alu_dec (
      .opcode    (bus.inst[6:0]),
      .funct3    (bus.inst[14:12]),
      .funct7_b5 (bus.inst[30]),
      .alu_op    (dec_alu_op)
   );

   always_comb begin
      a_sel = ALU_A_RS1;
      b_sel = ALU_B_RS2;
      case (cls)
         C_IALU, C_JALR, C_LOAD, C_STORE: b_sel = ALU_B_IMM;
         C_LUI: begin
            a_sel = ALU_A_ZERO;
            b_sel = ALU_B_IMM;
         end
         C_AUIPC, C_JAL: begin
            a_sel = ALU_A_PC;
            b_sel = ALU_B_IMM;
         end
         default: ;
      endcase
   end

   // The access that reaches the limit still gets this cycle's mem_ready first.
   assign wait_hit = (MEM_WAIT_MAX != 0) && (wait_cnt == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
      end else begin
         state <= state_nx;
         if (mem_req && !bus.mem_ready && state_nx == state && MEM_WAIT_MAX != 0)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
      end
   end

   always_comb begin
      state_nx     = state;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = PC_SEQ;
      reg_we       = 1'b0;
      wb_sel       = WB_ALU;
      imm_sel      = IMM_NONE;
      alu_a_sel    = ALU_A_RS1;
      alu_b_sel    = ALU_B_RS2;
      alu_op       = ALU_ADD;

      if (state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
         imm_sel   = imm_fmt(cls);
         alu_a_sel = a_sel;
         alu_b_sel = b_sel;
         alu_op    = dec_alu_op;
      end

      case (state)
         S_FETCH: begin
            mem_req = 1'b1;
            if (bus.mem_ready) begin
               ir_we    = 1'b1;
               state_nx = S_DECODE;
            end else if (wait_hit) begin
               state_nx = S_FAULT;
            end
         end
         S_DECODE: state_nx = S_EXEC;
         S_EXEC: begin
            case (cls)
               C_LOAD, C_STORE: state_nx = S_MEM;
               C_BRANCH: begin
                  pc_we    = 1'b1;
                  pc_sel   = bus.br_taken ? PC_IMM : PC_SEQ;
                  state_nx = S_FETCH;
               end
               C_ILLEGAL: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                  state_nx = S_FAULT;
`else
                  pc_we    = 1'b1;
                  state_nx = S_FETCH;
`endif
               end
               default: state_nx = S_WB;
            endcase
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = (cls == C_STORE);
            if (bus.mem_ready) begin
               if (cls == C_STORE) begin
                  pc_we    = 1'b1;
                  state_nx = S_FETCH;
               end else begin
                  state_nx = S_WB;
               end
            end else if (wait_hit) begin
               state_nx = S_FAULT;
            end
         end
         S_WB: begin
            reg_we   = 1'b1;
            pc_we    = 1'b1;
            pc_sel   = (cls == C_JAL) ? PC_IMM : (cls == C_JALR) ? PC_ALU : PC_SEQ;
            wb_sel   = (cls == C_LOAD) ? WB_MEM :
                       (cls == C_JAL || cls == C_JALR) ? WB_PC4 : WB_ALU;
            state_nx = S_FETCH;
         end
         S_FAULT: state_nx = S_FAULT;
         default: state_nx = S_FETCH;
      endcase
   end

   assign bus.mem_req      = mem_req;
   assign bus.mem_we       = mem_we;
   assign bus.mem_addr_sel = mem_addr_sel;
   assign bus.ir_we        = ir_we;
   assign bus.pc_we        = pc_we;
   assign bus.pc_sel       = pc_sel;
   assign bus.imm_sel      = imm_sel;
   assign bus.alu_a_sel    = alu_a_sel;
   assign bus.alu_b_sel    = alu_b_sel;
   assign bus.alu_op       = alu_op;
   assign bus.reg_we       = reg_we;
   assign bus.wb_sel       = wb_sel;
   assign bus.state_o      = state;
   assign bus.fault        = (state == S_FAULT);

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle RV32I core. It sequences instruction fetch, decode, execute, memory access and writeback over one shared memory port. It decodes the instruction register to drive the immediate generator format select, ALU operand and operation selects, PC update and register writeback strobes. It sits between the instruction register/branch comparator and the datapath muxes, and absorbs variable-latency memory through a req/ready handshake.

## Interface
- MEM_WAIT_MAX, 15: max consecutive wait cycles per memory access before fault; 0 disables the timeout.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- inst  in  32  instruction register contents.
- br_taken  in  1  branch comparator result for the current inst.
- mem_ready  in  1  memory accepts/completes the access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  store strobe, valid with mem_req.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_we  out  1  load IR from memory read data.
- pc_we  out  1  PC update strobe.
- pc_sel  out  2  0 = PC+4, 1 = PC+imm (branch/jal), 2 = ALU result with bit0 cleared (jalr).
- imm_sel  out  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J, 7 = none.
- alu_a_sel  out  2  0 = rs1, 1 = PC, 2 = zero.
- alu_b_sel  out  1  0 = rs2, 1 = imm.
- alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
- reg_we  out  1  register file write strobe.
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4.
- state_o  out  3  current state code.
- fault  out  1  sticky fault flag.

## Operation
- States:
  - FETCH=0: mem_req=1, mem_addr_sel=0. Hold until mem_ready. In the mem_ready cycle, ir_we=1, then go to DECODE.
  - DECODE=1: single cycle, goes to EXEC. imm_sel is valid from DECODE onward.
  - EXEC=2:
    - R-type and I-ALU: go to WB.
    - Load/store: alu_a_sel=0, alu_b_sel=1, ADD; go to MEM.
    - Branch: alu_op=SUB. pc_we=1 with pc_sel=1 if br_taken, else 0. Go to FETCH.
    - lui, auipc, jal, jalr: go to WB.
  - MEM=3: mem_req=1, mem_addr_sel=1, mem_we=1 for stores. Hold until mem_ready.
    - Load then goes to WB.
    - Store asserts pc_we with pc_sel=0 in the mem_ready cycle, then goes to FETCH.
  - WB=4: reg_we=1 and pc_we=1, then go to FETCH.
    - pc_sel: 1 for jal, 2 for jalr, else 0.
    - wb_sel: 1 for load, 2 for jal/jalr, else 0.
  - FAULT=5: all strobes 0, fault=1. Held until rst.
- ALU operand selects by class:
  - R-type: rs1/rs2.
  - I-ALU and jalr: rs1/imm.
  - lui: zero/imm.
  - auipc: PC/imm.
- alu_op for R-type: from funct3 plus funct7[5]; funct7[5] selects SUB and SRA.
- alu_op for I-ALU: from funct3; funct7[5] is used only for SRAI. All other classes use ADD.
- Decode outputs are combinational from the registered state and inst. Strobes are asserted only in the states listed above.
- Wait counter:
  - Counts cycles in FETCH/MEM with mem_req=1 and mem_ready=0. Clears on mem_ready and on every state change.
  - When the count reaches MEM_WAIT_MAX (nonzero), the next state is FAULT.
  - If mem_ready arrives in the same cycle the count reaches MEM_WAIT_MAX, mem_ready wins.
- An unrecognised opcode is handled in EXEC; see Configuration.

## Timing
- Reset values: state FETCH, wait count 0, fault 0. mem_req=1 (FETCH) in the first cycle after reset; every other strobe is 0.
- Latency with zero-wait memory:
  - Branch: 3 cycles.
  - R-type, I-ALU, U-type, jal, jalr, store: 4 cycles.
  - Load: 5 cycles.
  - Each memory wait cycle adds 1.
- mem_ready may be asserted in the first request cycle (zero-wait).
- mem_req stays high and mem_addr_sel/mem_we stay stable until mem_ready.
- rst during any state, including mid-access: next cycle is FETCH with the reset values above, and fault is cleared.
- mem_ready outside FETCH/MEM is ignored.

## Configuration
- MULTICYCLE_CTRL_ILLEGAL_TRAP_EN:
  - Defined: an unrecognised opcode in EXEC goes to FAULT, with no pc_we and no reg_we.
  - Undefined: an unrecognised opcode executes as a NOP. EXEC asserts pc_we with pc_sel=0, goes to FETCH, and fault never sets from decode.

## Structure
- Package multicycle_ctrl_pkg holds:
  - state encoding;
  - imm_sel, alu_op, pc_sel, wb_sel and alu_a_sel codes;
  - RV32I opcode constants.
- One sub-module, alu_op_decode: combinational mapping of opcode/funct3/funct7[5] to alu_op.

## Test plan
- addi x1,x0,5 (0x00500093), mem_ready tied 1:
  - States 0,1,2,4, then FETCH again.
  - imm_sel=0, alu_b_sel=1, alu_op=0.
  - reg_we=1 and pc_we=1 with pc_sel=0 in cycle 4.
- lw x2,8(x1) (0x0080a103) with mem_ready low for 2 MEM cycles:
  - mem_req high for 3 MEM cycles with mem_addr_sel=1.
  - WB with wb_sel=1; 7 cycles total.
- beq x1,x2,+8 (0x00208463):
  - With br_taken=1: EXEC asserts pc_we, pc_sel=1, imm_sel=2, alu_op=1, no reg_we; 3 cycles.
  - With br_taken=0: pc_sel=0.
- jalr x1,0(x1) (0x000080e7): WB asserts reg_we, wb_sel=2, pc_sel=2.
- MEM_WAIT_MAX=4, mem_ready held 0 in FETCH:
  - FAULT entered after 4 wait cycles; fault=1, mem_req=0.
  - rst then returns to FETCH with fault=0.
- inst 0xFFFFFFFF:
  - With macro: FAULT.
  - Without macro: pc_we with pc_sel=0 in EXEC, then FETCH.
  - rst asserted mid-MEM returns to FETCH next cycle.
